// File: rtl/mem_pkg.sv
// mem_pkg: definitions shared by the memory requester, the data memory and
// the testbench.
//   state_t        - requester FSM encoding, also exported for debug
//   MEM_WIDTH      - default data word width
//   MEM_ADDR_W     - default address width
//   MEM_LEN_W      - default burst-length field width
//   MEM_CNT_W      - default transaction counter width
package mem_pkg;

    localparam int MEM_WIDTH  = 8;
    localparam int MEM_ADDR_W = 8;
    localparam int MEM_LEN_W  = 4;
    localparam int MEM_CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

endpackage

// File: rtl/mem_requester.sv
// mem_requester: single-outstanding initiator for the shared data memory.
// A client issues single-beat writes or multi-beat reads; the block walks
// them out over the memory's write-address, write-data, read-address and
// read-data channels and returns read beats on a back-pressurable response
// port.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready           client command handshake
//   cmd_we, cmd_addr, cmd_wdata   command kind, start address, write data
//   cmd_len                       read beats minus one (ignored for writes)
//   rsp_valid/rsp_ready           read response handshake
//   rsp_data, rsp_last            response beat and end-of-burst marker
//   wa_valid/wa_ready/wa_addr     write-address channel
//   wd_valid/wd_ready/wd_data     write-data channel
//   ra_valid/ra_ready/ra_addr     read-address channel
//   rd_valid/rd_ready/rd_data     read-data channel
//   busy                          high whenever the FSM is not IDLE
//   wr_count, rd_count            completed writes / read beats (wrapping)
//   state                         current FSM state, for debug observation
//
// Handshake: on every channel a transfer happens on a rising edge where
// valid && ready. Once raised, a valid and its payload hold until that
// transfer. Every valid/ready this block drives is a flop that depends only
// on state, never combinationally on the partner's signal.
module mem_requester
    import mem_pkg::*;
#(
    parameter int WIDTH  = MEM_WIDTH,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int LEN_W  = MEM_LEN_W,
    parameter int CNT_W  = MEM_CNT_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [WIDTH-1:0]  cmd_wdata,
    input  logic [LEN_W-1:0]  cmd_len,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_last,

    output logic              wa_valid,
    input  logic              wa_ready,
    output logic [ADDR_W-1:0] wa_addr,

    output logic              wd_valid,
    input  logic              wd_ready,
    output logic [WIDTH-1:0]  wd_data,

    output logic              ra_valid,
    input  logic              ra_ready,
    output logic [ADDR_W-1:0] ra_addr,

    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [WIDTH-1:0]  rd_data,

    output logic              busy,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count,
    output state_t            state
);

    // Working copy of the in-flight command.
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
    logic [LEN_W-1:0]  beats_left;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            wa_valid   <= 1'b0;
            wa_addr    <= '0;
            wd_valid   <= 1'b0;
            wd_data    <= '0;
            ra_valid   <= 1'b0;
            ra_addr    <= '0;
            rd_ready   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_last   <= 1'b0;
            wr_count   <= '0;
            rd_count   <= '0;
            addr       <= '0;
            wdata      <= '0;
            beats_left <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // cmd_ready is high in IDLE, so cmd_valid alone means accept.
                    if (cmd_valid) begin
                        addr       <= cmd_addr;
                        wdata      <= cmd_wdata;
                        beats_left <= cmd_len;
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        if (cmd_we) begin
                            wa_valid <= 1'b1;
                            wa_addr  <= cmd_addr;
                            state    <= WR_ADDR;
                        end else begin
                            ra_valid <= 1'b1;
                            ra_addr  <= cmd_addr;
                            state    <= RD_ADDR;
                        end
                    end
                end

                WR_ADDR: begin
                    // Address strictly before data: the memory receives in that order.
                    if (wa_ready) begin
                        wa_valid <= 1'b0;
                        wd_valid <= 1'b1;
                        wd_data  <= wdata;
                        state    <= WR_DATA;
                    end
                end

                WR_DATA: begin
                    if (wd_ready) begin
                        wd_valid  <= 1'b0;
                        wr_count  <= wr_count + 1'b1;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                RD_ADDR: begin
                    if (ra_ready) begin
                        ra_valid <= 1'b0;
                        rd_ready <= 1'b1;
                        state    <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    // One-entry response register: capture the beat and stop
                    // accepting read data until the client takes it.
                    if (rd_valid) begin
                        rd_ready  <= 1'b0;
                        rsp_data  <= rd_data;
                        rsp_valid <= 1'b1;
                        rsp_last  <= (beats_left == '0);
                        state     <= RSP;
                    end
                end

                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        rd_count  <= rd_count + 1'b1;
                        if (beats_left == '0) begin
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            // Next beat: address wraps naturally at ADDR_W bits.
                            addr       <= addr + 1'b1;
                            ra_addr    <= addr + 1'b1;
                            ra_valid   <= 1'b1;
                            beats_left <= beats_left - 1'b1;
                            state      <= RD_ADDR;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    wa_valid  <= 1'b0;
                    wd_valid  <= 1'b0;
                    ra_valid  <= 1'b0;
                    rd_ready  <= 1'b0;
                    rsp_valid <= 1'b0;
                    rsp_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_requester.sv
// Directed testbench for mem_requester with a small behavioural memory.
module tb_mem_requester;
    import mem_pkg::*;

    localparam int WIDTH  = MEM_WIDTH;
    localparam int ADDR_W = MEM_ADDR_W;
    localparam int LEN_W  = MEM_LEN_W;
    localparam int CNT_W  = MEM_CNT_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_we = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [WIDTH-1:0]  cmd_wdata = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [WIDTH-1:0]  rsp_data;
    logic              rsp_last;
    logic              wa_valid;
    logic              wa_ready = 1'b1;
    logic [ADDR_W-1:0] wa_addr;
    logic              wd_valid;
    logic              wd_ready = 1'b1;
    logic [WIDTH-1:0]  wd_data;
    logic              ra_valid;
    logic              ra_ready = 1'b1;
    logic [ADDR_W-1:0] ra_addr;
    logic              rd_valid;
    logic              rd_ready;
    logic [WIDTH-1:0]  rd_data;
    logic              busy;
    logic [CNT_W-1:0]  wr_count;
    logic [CNT_W-1:0]  rd_count;
    state_t            state;

    mem_requester dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last),
        .wa_valid(wa_valid), .wa_ready(wa_ready), .wa_addr(wa_addr),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .ra_valid(ra_valid), .ra_ready(ra_ready), .ra_addr(ra_addr),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .wr_count(wr_count), .rd_count(rd_count), .state(state)
    );

    // ---------------- memory model and monitors ----------------
    logic [WIDTH-1:0]  mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] wa_lat;
    logic [ADDR_W-1:0] ra_log [$];
    logic [WIDTH-1:0]  rsp_log [$];
    logic              last_log [$];

    always @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wa_valid && wa_ready) wa_lat <= wa_addr;
            if (wd_valid && wd_ready) mem[wa_lat] <= wd_data;
            if (ra_valid && ra_ready) begin
                ra_log.push_back(ra_addr);
                rd_valid <= 1'b1;
                rd_data  <= mem[ra_addr];
            end else if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
            end
            if (rsp_valid && rsp_ready) begin
                rsp_log.push_back(rsp_data);
                last_log.push_back(rsp_last);
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass = 0;
    logic [WIDTH-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    // Presents a command from a negedge, waits for cmd_ready, and returns at
    // the negedge following the accepting edge with cmd_valid dropped.
    task automatic send_cmd(input logic we, input logic [ADDR_W-1:0] a,
                            input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] len);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_len   = len;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("cmd_accept_busy", busy, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [ADDR_W-1:0] exp_ra [4];
        int n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        // Reset state
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_wa_valid", wa_valid, 0);
        check("rst_wd_valid", wd_valid, 0);
        check("rst_ra_valid", ra_valid, 0);
        check("rst_rd_ready", rd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_last", rsp_last, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_rd_count", rd_count, 0);
        check("rst_state", state, IDLE);
        reset = 1'b0;

        // Single write with exact cycle timing
        send_cmd(1'b1, 8'd200, 8'h5A, 4'd0);
        check("wr_wa_valid", wa_valid, 1);
        check("wr_wa_addr", wa_addr, 200);
        @(negedge clk);
        check("wr_wd_valid", wd_valid, 1);
        check("wr_wd_data", wd_data, 8'h5A);
        check("wr_wa_dropped", wa_valid, 0);
        @(negedge clk);
        check("wr_cmd_ready", cmd_ready, 1);
        check("wr_count_1", wr_count, 1);
        check("wr_busy_low", busy, 0);
        check("wr_mem_200", mem[200], 8'h5A);

        // Preload through the write path
        send_cmd(1'b1, 8'd254, 8'h11, 4'd0); wait_idle("pre_idle0");
        send_cmd(1'b1, 8'd255, 8'h22, 4'd0); wait_idle("pre_idle1");
        send_cmd(1'b1, 8'd0,   8'h33, 4'd0); wait_idle("pre_idle2");
        send_cmd(1'b1, 8'd1,   8'h44, 4'd0); wait_idle("pre_idle3");
        send_cmd(1'b1, 8'd10,  8'hA5, 4'd0); wait_idle("pre_idle4");
        send_cmd(1'b1, 8'd11,  8'h5C, 4'd0); wait_idle("pre_idle5");
        check("pre_wr_count", wr_count, 7);

        // Burst read wrapping past the top of memory
        ra_log.delete(); rsp_log.delete(); last_log.delete();
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        exp_ra[0] = 8'd254; exp_ra[1] = 8'd255; exp_ra[2] = 8'd0; exp_ra[3] = 8'd1;
        send_cmd(1'b0, 8'd254, 8'h00, 4'd3);
        check("rd_ra_valid", ra_valid, 1);
        check("rd_ra_addr0", ra_addr, 254);
        @(negedge clk);
        check("rd_rd_ready", rd_ready, 1);
        @(negedge clk);
        check("rd_rsp_valid_t3", rsp_valid, 1);
        check("rd_rsp_data_t3", rsp_data, 8'h11);
        wait_idle("burst_idle");
        check("burst_ra_count", ra_log.size(), 4);
        check("burst_rsp_count", rsp_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("burst_ra_%0d", i), ra_log[i], exp_ra[i]);
            check($sformatf("burst_data_%0d", i), rsp_log[i], exp_q.pop_front());
            check($sformatf("burst_last_%0d", i), last_log[i], (i == 3) ? 1 : 0);
        end
        check("burst_rd_count", rd_count, 4);

        // Response back-pressure during a 2-beat read
        ra_log.delete(); rsp_log.delete(); last_log.delete();
        rsp_ready = 1'b0;
        send_cmd(1'b0, 8'd10, 8'h00, 4'd1);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_seen", rsp_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_data", rsp_data, 8'hA5);
            check("bp_rsp_last", rsp_last, 0);
            check("bp_no_ra", ra_valid, 0);
        end
        rsp_ready = 1'b1;
        wait_idle("bp_idle");
        check("bp_rsp_count", rsp_log.size(), 2);
        check("bp_data0", rsp_log[0], 8'hA5);
        check("bp_data1", rsp_log[1], 8'h5C);
        check("bp_last1", last_log[1], 1);
        check("bp_ra1", ra_log[1], 11);
        check("bp_rd_count", rd_count, 6);

        // Write-data stall
        wd_ready = 1'b0;
        send_cmd(1'b1, 8'd50, 8'h3C, 4'd0);
        check("stall_wa_valid", wa_valid, 1);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("stall_wd_valid", wd_valid, 1);
            check("stall_wd_data", wd_data, 8'h3C);
            check("stall_busy", busy, 1);
            check("stall_state", state, WR_DATA);
            check("stall_wr_count", wr_count, 7);
            if (k < 3) @(negedge clk);
        end
        wd_ready = 1'b1;
        @(negedge clk);
        check("stall_done_busy", busy, 0);
        check("stall_done_count", wr_count, 8);
        check("stall_mem_50", mem[50], 8'h3C);

        // Read presented while a write is stalled
        rsp_log.delete(); last_log.delete();
        wd_ready = 1'b0;
        send_cmd(1'b1, 8'd60, 8'h77, 4'd0);
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 8'd60;
        cmd_len   = 4'd0;
        for (int k = 0; k < 3; k++) begin
            check("hold_cmd_ready", cmd_ready, 0);
            @(negedge clk);
        end
        wd_ready = 1'b1;
        @(negedge clk);
        check("hold_idle_ready", cmd_ready, 1);
        check("hold_wr_count", wr_count, 9);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("hold_ra_valid", ra_valid, 1);
        check("hold_ra_addr", ra_addr, 60);
        wait_idle("hold_idle");
        check("hold_rsp_data", rsp_log[0], 8'h77);
        check("hold_rd_count", rd_count, 7);

        // Reset during RD_DATA of beat 2 of a 4-beat read
        ra_log.delete();
        send_cmd(1'b0, 8'd254, 8'h00, 4'd3);
        n = 0;
        while (!(ra_log.size() == 2 && rd_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_in_rd_data", state, RD_DATA);
        check("mid_beat1_counted", rd_count, 8);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_wa_valid", wa_valid, 0);
        check("mid_rst_wd_valid", wd_valid, 0);
        check("mid_rst_ra_valid", ra_valid, 0);
        check("mid_rst_rd_ready", rd_ready, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rsp_data", rsp_data, 0);
        check("mid_rst_wr_count", wr_count, 0);
        check("mid_rst_rd_count", rd_count, 0);
        reset = 1'b0;

        rsp_log.delete();
        send_cmd(1'b1, 8'd5, 8'h99, 4'd0);
        wait_idle("post_wr_idle");
        check("post_wr_count", wr_count, 1);
        check("post_mem_5", mem[5], 8'h99);
        send_cmd(1'b0, 8'd5, 8'h00, 4'd0);
        wait_idle("post_rd_idle");
        check("post_rd_data", rsp_log[0], 8'h99);
        check("post_rd_count", rd_count, 1);

        // Report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
